// File: rtl/mips_pkg.sv
// Shared MIPS I encodings and architectural constants for the Harvard core.
package mips_pkg;

  localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;
  localparam logic [31:0] HALT_ADDR    = 32'h0000_0000;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  localparam logic [4:0] RT_BLTZ = 5'd0;
  localparam logic [4:0] RT_BGEZ = 5'd1;

  typedef struct packed {
    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] shamt;
    logic [5:0] funct;
  } instr_t;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/mips_regfile.sv
// 32x32 general-purpose register file: two combinational reads, one write, $2 tapped out.
module mips_regfile (
  input  logic        clk,
  input  logic        reset_i,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr_a_i,
  output logic [31:0] rdata_a_o,
  input  logic [4:0]  raddr_b_i,
  output logic [31:0] rdata_b_o,
  output logic [31:0] v0_o
);

  logic [31:0] regs_q [32];

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= 32'd0;
    end else if (we_i && (waddr_i != 5'd0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // $0 is hardwired even though it is never written.
  assign rdata_a_o = (raddr_a_i == 5'd0) ? 32'd0 : regs_q[raddr_a_i];
  assign rdata_b_o = (raddr_b_i == 5'd0) ? 32'd0 : regs_q[raddr_b_i];
  assign v0_o      = regs_q[2];

endmodule

// File: rtl/mips_cpu_harvard_core.sv
// Single-cycle MIPS I core with one branch delay slot (pc/pc_next pair) and halt-on-jump-to-0.
module mips_cpu_harvard_core
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  output logic        active,
  output logic [31:0] register_v0,
  output logic [31:0] instr_address,
  input  logic [31:0] instr_readdata,
  output logic [31:0] data_address,
  output logic        data_write,
  output logic        data_read,
  output logic [31:0] data_writedata,
  input  logic [31:0] data_readdata
);

  logic [31:0] pc_q, pc_d, pc_next_q, pc_next_d;
  logic        active_q, active_d;
  logic        commit;

  instr_t      ins;
  logic [31:0] rs_val, rt_val, imm_s, imm_z;
  logic [31:0] pc_plus4, pc_plus8, br_target, j_target;

  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        taken;
  logic [31:0] jump_to;
  logic        is_lw, is_sw;

  assign ins       = instr_readdata;
  assign imm_s     = sext16(instr_readdata[15:0]);
  assign imm_z     = {16'd0, instr_readdata[15:0]};
  assign pc_plus4  = pc_q + 32'd4;
  assign pc_plus8  = pc_q + 32'd8;
  assign br_target = pc_plus4 + {imm_s[29:0], 2'b00};
  assign j_target  = {pc_plus4[31:28], instr_readdata[25:0], 2'b00};
  assign commit    = active_q & clk_enable;

  mips_regfile u_regfile (
    .clk       (clk),
    .reset_i   (reset),
    .we_i      (commit & wb_en),
    .waddr_i   (wb_addr),
    .wdata_i   (wb_data),
    .raddr_a_i (ins.rs),
    .rdata_a_o (rs_val),
    .raddr_b_i (ins.rt),
    .rdata_b_o (rt_val),
    .v0_o      (register_v0)
  );

  always_comb begin
    wb_en   = 1'b0;
    wb_addr = ins.rd;
    wb_data = 32'd0;
    taken   = 1'b0;
    jump_to = br_target;
    is_lw   = 1'b0;
    is_sw   = 1'b0;
    case (ins.op)
      OP_SPECIAL: begin
        wb_en = 1'b1;
        case (ins.funct)
          FN_SLL:  wb_data = rt_val << ins.shamt;
          FN_SRL:  wb_data = rt_val >> ins.shamt;
          FN_SRA:  wb_data = $signed(rt_val) >>> ins.shamt;
          FN_SLLV: wb_data = rt_val << rs_val[4:0];
          FN_SRLV: wb_data = rt_val >> rs_val[4:0];
          FN_SRAV: wb_data = $signed(rt_val) >>> rs_val[4:0];
          FN_ADDU: wb_data = rs_val + rt_val;
          FN_SUBU: wb_data = rs_val - rt_val;
          FN_AND:  wb_data = rs_val & rt_val;
          FN_OR:   wb_data = rs_val | rt_val;
          FN_XOR:  wb_data = rs_val ^ rt_val;
          FN_NOR:  wb_data = ~(rs_val | rt_val);
          FN_SLT:  wb_data = {31'd0, $signed(rs_val) < $signed(rt_val)};
          FN_SLTU: wb_data = {31'd0, rs_val < rt_val};
          FN_JR: begin
            wb_en   = 1'b0;
            taken   = 1'b1;
            jump_to = rs_val;
          end
          FN_JALR: begin
            taken   = 1'b1;
            jump_to = rs_val;
            wb_data = pc_plus8;
          end
          default: wb_en = 1'b0;
        endcase
      end
      OP_REGIMM: begin
        if (ins.rt == RT_BLTZ)      taken = rs_val[31];
        else if (ins.rt == RT_BGEZ) taken = ~rs_val[31];
      end
      OP_J: begin
        taken   = 1'b1;
        jump_to = j_target;
      end
      OP_JAL: begin
        taken   = 1'b1;
        jump_to = j_target;
        wb_en   = 1'b1;
        wb_addr = 5'd31;
        wb_data = pc_plus8;
      end
      OP_BEQ:  taken = (rs_val == rt_val);
      OP_BNE:  taken = (rs_val != rt_val);
      OP_BLEZ: taken = rs_val[31] | (rs_val == 32'd0);
      OP_BGTZ: taken = ~rs_val[31] & (rs_val != 32'd0);
      OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        wb_en   = 1'b1;
        wb_addr = ins.rt;
        case (ins.op)
          OP_ADDIU: wb_data = rs_val + imm_s;
          OP_SLTI:  wb_data = {31'd0, $signed(rs_val) < $signed(imm_s)};
          OP_SLTIU: wb_data = {31'd0, rs_val < imm_s};
          OP_ANDI:  wb_data = rs_val & imm_z;
          OP_ORI:   wb_data = rs_val | imm_z;
          OP_XORI:  wb_data = rs_val ^ imm_z;
          default:  wb_data = {instr_readdata[15:0], 16'd0};
        endcase
      end
      OP_LW: begin
        is_lw   = 1'b1;
        wb_en   = 1'b1;
        wb_addr = ins.rt;
        wb_data = data_readdata;
      end
      OP_SW: is_sw = 1'b1;
      default: ;
    endcase
  end

  // The instruction at pc always commits; reaching HALT_ADDR only stops the PC from advancing.
  always_comb begin
    pc_d      = pc_q;
    pc_next_d = pc_next_q;
    active_d  = active_q;
    if (commit) begin
      if (pc_next_q == HALT_ADDR) begin
        active_d = 1'b0;
      end else begin
        pc_d      = pc_next_q;
        pc_next_d = taken ? jump_to : (pc_next_q + 32'd4);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q      <= RESET_VECTOR;
      pc_next_q <= RESET_VECTOR + 32'd4;
      active_q  <= 1'b1;
    end else begin
      pc_q      <= pc_d;
      pc_next_q <= pc_next_d;
      active_q  <= active_d;
    end
  end

  assign active         = active_q;
  assign instr_address  = pc_q;
  assign data_address   = rs_val + imm_s;
  assign data_writedata = rt_val;
  assign data_read      = is_lw & active_q & ~reset;
  assign data_write     = is_sw & commit & ~reset;

endmodule

// File: tb/tb_mips_cpu_harvard_core.sv
// Bench for mips_cpu_harvard_core: directed programs plus random programs checked cycle by cycle against an ISA model.
module tb_mips_cpu_harvard_core;

  localparam logic [31:0] BASE = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        reset, clk_enable;
  logic        active, data_write, data_read;
  logic [31:0] register_v0, instr_address, instr_readdata;
  logic [31:0] data_address, data_writedata, data_readdata;

  always #5 clk = ~clk;

  mips_cpu_harvard_core dut (
    .clk            (clk),
    .reset          (reset),
    .clk_enable     (clk_enable),
    .active         (active),
    .register_v0    (register_v0),
    .instr_address  (instr_address),
    .instr_readdata (instr_readdata),
    .data_address   (data_address),
    .data_write     (data_write),
    .data_read      (data_read),
    .data_writedata (data_writedata),
    .data_readdata  (data_readdata)
  );

  // Memory model: 256-word ROM at BASE, 256-word RAM at 0, out-of-range reads return 0.
  logic [31:0] imem [256];
  logic [31:0] dmem [256];
  logic [31:0] dmem_init [256];
  logic [31:0] ioff;
  int          wr_count;
  logic [31:0] last_wa, last_wd;

  assign ioff           = instr_address - BASE;
  assign instr_readdata = (ioff < 32'd1024) ? imem[ioff[9:2]] : 32'd0;
  assign data_readdata  = (data_address < 32'd1024) ? dmem[data_address[9:2]] : 32'd0;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) dmem[i] <= dmem_init[i];
      wr_count <= 0;
    end else if (data_write) begin
      if (data_address < 32'd1024) dmem[data_address[9:2]] <= data_writedata;
      wr_count <= wr_count + 1;
      last_wa  <= data_address;
      last_wd  <= data_writedata;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;
  int cur_cyc  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", tag, cur_cyc, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh);
    return {6'd0, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] idx);
    return {op, idx};
  endfunction

  // ISA-level reference model.
  logic [31:0] m_regs [32];
  logic [31:0] m_dmem [256];
  logic [31:0] m_pc, m_npc;
  bit          m_active;

  function automatic logic [31:0] model_fetch(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return (off < 32'd1024) ? imem[off[9:2]] : 32'd0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    for (int i = 0; i < 256; i++) m_dmem[i] = dmem_init[i];
    m_pc     = BASE;
    m_npc    = BASE + 32'd4;
    m_active = 1'b1;
  endtask

  task automatic model_step();
    logic [31:0] ins, a, b, se, ze, p4, nxt, wd, addr;
    logic [4:0]  rs, rt, rd, sh, wa;
    logic [5:0]  op, fn;
    bit          wr;
    ins = model_fetch(m_pc);
    op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11]; sh = ins[10:6]; fn = ins[5:0];
    a  = m_regs[rs]; b = m_regs[rt];
    se = {{16{ins[15]}}, ins[15:0]};
    ze = {16'd0, ins[15:0]};
    p4 = m_pc + 32'd4;
    nxt = m_npc + 32'd4;
    wr = 1'b0; wa = rd; wd = 32'd0;
    case (op)
      6'h00: begin
        wr = 1'b1;
        case (fn)
          6'h00: wd = b << sh;
          6'h02: wd = b >> sh;
          6'h03: wd = $signed(b) >>> sh;
          6'h04: wd = b << a[4:0];
          6'h06: wd = b >> a[4:0];
          6'h07: wd = $signed(b) >>> a[4:0];
          6'h08: begin wr = 1'b0; nxt = a; end
          6'h09: begin nxt = a; wd = m_pc + 32'd8; end
          6'h21: wd = a + b;
          6'h23: wd = a - b;
          6'h24: wd = a & b;
          6'h25: wd = a | b;
          6'h26: wd = a ^ b;
          6'h27: wd = ~(a | b);
          6'h2A: wd = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
          6'h2B: wd = (a < b) ? 32'd1 : 32'd0;
          default: wr = 1'b0;
        endcase
      end
      6'h01: begin
        if ((rt == 5'd0 && int'(a) < 0) || (rt == 5'd1 && int'(a) >= 0)) nxt = p4 + (se << 2);
      end
      6'h02: nxt = {p4[31:28], ins[25:0], 2'b00};
      6'h03: begin nxt = {p4[31:28], ins[25:0], 2'b00}; wr = 1'b1; wa = 5'd31; wd = m_pc + 32'd8; end
      6'h04: if (a == b) nxt = p4 + (se << 2);
      6'h05: if (a != b) nxt = p4 + (se << 2);
      6'h06: if (int'(a) <= 0) nxt = p4 + (se << 2);
      6'h07: if (int'(a) > 0) nxt = p4 + (se << 2);
      6'h09: begin wr = 1'b1; wa = rt; wd = a + se; end
      6'h0A: begin wr = 1'b1; wa = rt; wd = (int'(a) < int'(se)) ? 32'd1 : 32'd0; end
      6'h0B: begin wr = 1'b1; wa = rt; wd = (a < se) ? 32'd1 : 32'd0; end
      6'h0C: begin wr = 1'b1; wa = rt; wd = a & ze; end
      6'h0D: begin wr = 1'b1; wa = rt; wd = a | ze; end
      6'h0E: begin wr = 1'b1; wa = rt; wd = a ^ ze; end
      6'h0F: begin wr = 1'b1; wa = rt; wd = ze << 16; end
      6'h23: begin
        addr = a + se; wr = 1'b1; wa = rt;
        wd = (addr < 32'd1024) ? m_dmem[addr[9:2]] : 32'd0;
      end
      6'h2B: begin
        addr = a + se;
        if (addr < 32'd1024) m_dmem[addr[9:2]] = b;
      end
      default: ;
    endcase
    if (wr && wa != 5'd0) m_regs[wa] = wd;
    if (m_npc == 32'd0) m_active = 1'b0;
    else begin
      m_pc  = m_npc;
      m_npc = nxt;
    end
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = 32'd0;
  endtask

  // Resets the DUT, then runs to halt (+3 cycles) comparing all outputs every cycle.
  task automatic run_prog(input int stall_start, input int stall_len, input bit rand_stall, output int halt_cyc);
    logic [31:0] ins, se;
    bit          en;
    int          post;
    @(negedge clk);
    reset = 1'b1;
    clk_enable = 1'b1;
    #1;
    cur_cyc = -1;
    check_eq("rst_active", {31'd0, active}, 32'd1);
    check_eq("rst_pc", instr_address, BASE);
    check_eq("rst_v0", register_v0, 32'd0);
    check_eq("rst_dwrite", {31'd0, data_write}, 32'd0);
    check_eq("rst_dread", {31'd0, data_read}, 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    halt_cyc = -1;
    post = 0;
    cur_cyc = 0;
    while (cur_cyc < 1000 && post < 3) begin
      en = !((cur_cyc >= stall_start && cur_cyc < stall_start + stall_len) ||
             (rand_stall && $urandom_range(0, 4) == 0));
      clk_enable = en;
      #1;
      ins = model_fetch(m_pc);
      se  = {{16{ins[15]}}, ins[15:0]};
      check_eq("pc", instr_address, m_pc);
      check_eq("v0", register_v0, m_regs[2]);
      check_eq("active", {31'd0, active}, {31'd0, m_active});
      check_eq("dwrite", {31'd0, data_write}, {31'd0, m_active && en && ins[31:26] == 6'h2B});
      check_eq("dread", {31'd0, data_read}, {31'd0, m_active && ins[31:26] == 6'h23});
      if (m_active && (ins[31:26] == 6'h2B || ins[31:26] == 6'h23))
        check_eq("daddr", data_address, m_regs[ins[25:21]] + se);
      if (m_active && en && ins[31:26] == 6'h2B)
        check_eq("wdata", data_writedata, m_regs[ins[20:16]]);
      if (!active && halt_cyc < 0) halt_cyc = cur_cyc;
      @(posedge clk);
      if (en && m_active) model_step();
      if (!m_active) post++;
      @(negedge clk);
      cur_cyc++;
    end
    if (post < 3) check_eq("halt_timeout", {31'd0, active}, 32'd0);
    clk_enable = 1'b1;
  endtask

  task automatic gen_random_prog(input int len);
    logic [5:0] rfn [14] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h21,
                             6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
    logic [5:0] iop [7]  = '{6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F};
    logic [5:0] bop [5]  = '{6'h01, 6'h04, 6'h05, 6'h06, 6'h07};
    logic [4:0] rd;
    logic [5:0] op;
    bit         prev_br;
    int         k, maxo;
    clear_imem();
    prev_br = 1'b0;
    for (int i = 0; i < len; i++) begin
      k  = $urandom_range(0, 10);
      rd = ($urandom_range(0, 2) == 0) ? 5'd2 : 5'($urandom_range(1, 7));
      if (k == 0 && !prev_br && i <= len - 2) begin
        maxo = len - (i + 1);
        if (maxo > 3) maxo = 3;
        op = bop[$urandom_range(0, 4)];
        imem[i] = enc_i(op, 5'($urandom_range(0, 7)),
                        (op == 6'h01) ? 5'($urandom_range(0, 1)) : 5'($urandom_range(0, 7)),
                        16'($urandom_range(0, maxo)));
        prev_br = 1'b1;
      end else begin
        prev_br = 1'b0;
        if (k <= 4)
          imem[i] = enc_r(rfn[$urandom_range(0, 13)], 5'($urandom_range(0, 7)),
                          5'($urandom_range(0, 7)), rd, 5'($urandom_range(0, 31)));
        else if (k <= 7)
          imem[i] = enc_i(iop[$urandom_range(0, 6)], 5'($urandom_range(0, 7)), rd, 16'($urandom));
        else if (k == 8)
          imem[i] = enc_i(6'h23, 5'd0, rd, 16'($urandom_range(0, 63) * 4));
        else if (k == 9)
          imem[i] = enc_i(6'h2B, 5'd0, 5'($urandom_range(0, 7)), 16'($urandom_range(0, 63) * 4));
        else
          imem[i] = enc_i(6'h3F, 5'($urandom_range(0, 7)), rd, 16'($urandom));
      end
    end
    imem[len]     = enc_r(6'h08, 5'd0, 5'd0, 5'd0, 5'd0);
    imem[len + 1] = 32'd0;
  endtask

  task automatic load_prog2();
    clear_imem();
    imem[0] = enc_i(6'h0F, 5'd0, 5'd3, 16'h1234);
    imem[1] = enc_i(6'h0D, 5'd3, 5'd3, 16'h5678);
    imem[2] = enc_i(6'h2B, 5'd0, 5'd3, 16'h0000);
    imem[3] = enc_i(6'h23, 5'd0, 5'd2, 16'h0000);
    imem[4] = enc_r(6'h08, 5'd0, 5'd0, 5'd0, 5'd0);
    imem[5] = 32'd0;
  endtask

  int halt_cyc;

  initial begin
    reset = 1'b1;
    clk_enable = 1'b0;
    for (int i = 0; i < 256; i++) dmem_init[i] = 32'd0;

    clear_imem();
    imem[0] = enc_i(6'h09, 5'd0, 5'd2, 16'd5);
    imem[1] = enc_r(6'h08, 5'd0, 5'd0, 5'd0, 5'd0);
    run_prog(-1, 0, 1'b0, halt_cyc);
    check_eq("t1_v0", register_v0, 32'd5);
    check_eq("t1_halt_within4", {31'd0, halt_cyc >= 0 && halt_cyc <= 4}, 32'd1);
    $display("txn t1 addiu/jr: v0=%h halt_cyc=%0d", register_v0, halt_cyc);

    load_prog2();
    run_prog(-1, 0, 1'b0, halt_cyc);
    check_eq("t2_wr_count", 32'(wr_count), 32'd1);
    check_eq("t2_wr_addr", last_wa, 32'd0);
    check_eq("t2_wr_data", last_wd, 32'h1234_5678);
    check_eq("t2_v0", register_v0, 32'h1234_5678);
    $display("txn t2 lui/ori/sw/lw: v0=%h writes=%0d", register_v0, wr_count);

    clear_imem();
    imem[0] = enc_i(6'h04, 5'd0, 5'd0, 16'd2);
    imem[1] = enc_i(6'h09, 5'd0, 5'd2, 16'd1);
    imem[2] = enc_i(6'h09, 5'd0, 5'd2, 16'd99);
    imem[3] = enc_i(6'h09, 5'd2, 5'd2, 16'd10);
    imem[4] = enc_r(6'h08, 5'd0, 5'd0, 5'd0, 5'd0);
    run_prog(-1, 0, 1'b0, halt_cyc);
    check_eq("t3_v0", register_v0, 32'd11);
    $display("txn t3 beq delay slot: v0=%h", register_v0);

    clear_imem();
    imem[0] = enc_j(6'h03, 26'h3F0_0004);
    imem[4] = enc_r(6'h21, 5'd31, 5'd0, 5'd2, 5'd0);
    imem[5] = enc_r(6'h08, 5'd0, 5'd0, 5'd0, 5'd0);
    run_prog(-1, 0, 1'b0, halt_cyc);
    check_eq("t4_v0", register_v0, 32'hBFC0_0008);
    $display("txn t4 jal link: v0=%h", register_v0);

    load_prog2();
    run_prog(2, 5, 1'b0, halt_cyc);
    check_eq("t5_v0", register_v0, 32'h1234_5678);
    check_eq("t5_wr_count", 32'(wr_count), 32'd1);
    $display("txn t5 stalled run: v0=%h writes=%0d", register_v0, wr_count);

    // DUT is halted here; run_prog asserts reset and checks the restored state at once.
    run_prog(-1, 0, 1'b0, halt_cyc);
    check_eq("t6_v0", register_v0, 32'h1234_5678);
    $display("txn t6 reset while halted: v0=%h", register_v0);

    for (int p = 0; p < 25; p++) begin
      for (int i = 0; i < 256; i++) dmem_init[i] = $urandom;
      gen_random_prog($urandom_range(8, 40));
      run_prog(-1, 0, (p % 2) == 1, halt_cyc);
      $display("txn rand%0d: v0=%h model_v0=%h halt_cyc=%0d", p, register_v0, m_regs[2], halt_cyc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
